// File: rtl/sort_pkg.sv
// Shared definitions for the rank-based streaming sorter.
package sort_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RANK  = 2'd1,
        ST_DRAIN = 2'd2
    } sort_state_t;

endpackage

// File: rtl/rank_cmp_row.sv
// One row of the rank matrix: marks every element that must sort ahead of the reference element.
module rank_cmp_row #(
    parameter int DATASIZE = 8,
    parameter int DEPTH    = 32,
    parameter int DESCEND  = 0
) (
    input  logic [DATASIZE-1:0]       ref_data,
    input  logic [$clog2(DEPTH)-1:0]  ref_idx,
    input  logic [DEPTH*DATASIZE-1:0] all_data,
    output logic [DEPTH-1:0]          cmp_vec
);

    always_comb begin
        cmp_vec = '0;
        for (int j = 0; j < DEPTH; j++) begin
            // Equal values ahead only when they arrived earlier, keeping the order stable.
            if (DESCEND != 0)
                cmp_vec[j] = (all_data[j*DATASIZE +: DATASIZE] > ref_data) |
                             ((all_data[j*DATASIZE +: DATASIZE] == ref_data) && (j < int'(ref_idx)));
            else
                cmp_vec[j] = (all_data[j*DATASIZE +: DATASIZE] < ref_data) |
                             ((all_data[j*DATASIZE +: DATASIZE] == ref_data) && (j < int'(ref_idx)));
        end
    end

endmodule

// File: rtl/rank_sort_stream.sv
// Frame sorter: load DEPTH elements, rank each one through a 2-stage pipeline, drain in sorted order.
module rank_sort_stream
    import sort_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int DEPTH    = 32,
    parameter int DESCEND  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [DATASIZE-1:0]      in_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [DATASIZE-1:0]      out_data,
    output logic [$clog2(DEPTH)-1:0] out_idx,
    output logic                     out_last,
    output logic                     busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] DEPTH_C  = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] LOAD_END = (IDX_W+1)'(DEPTH - 1);
    localparam logic [IDX_W:0] RANK_END = (IDX_W+1)'(DEPTH + 1);
    localparam logic [IDX_W:0] LAST_C   = (IDX_W+1)'(DEPTH - 1);

    function automatic logic [IDX_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [IDX_W-1:0] c;
        c = '0;
        for (int k = 0; k < DEPTH; k++)
            c = c + IDX_W'(v[k]);
        return c;
    endfunction

    sort_state_t state, state_nxt;

    logic [IDX_W:0]            load_cnt, rank_cnt, drain_addr;
    logic                      in_hs, out_hs, load_last, rank_done, drain_load;
    logic [IDX_W-1:0]          rank_idx, rank_addr;
    logic [DEPTH-1:0]          cmp_vec;
    logic [DATASIZE-1:0]       load_mem [DEPTH];
    logic [DEPTH*DATASIZE-1:0] load_flat;
    logic [DATASIZE-1:0]       buf_data [DEPTH];
    logic [IDX_W-1:0]          buf_idx  [DEPTH];

    logic                      vld_p1;
    logic [DEPTH-1:0]          cmp_p1;
    logic [IDX_W-1:0]          idx_p1;
    logic [DATASIZE-1:0]       data_p1;

    logic [DATASIZE-1:0]       out_data_q;
    logic [IDX_W-1:0]          out_idx_q;

    assign in_hs      = in_vld & in_rdy;
    assign out_hs     = out_vld & out_rdy;
    assign load_last  = (load_cnt == LOAD_END);
    assign rank_done  = (rank_cnt == RANK_END);
    assign rank_idx   = rank_cnt[IDX_W-1:0];
    assign rank_addr  = popcount(cmp_p1);
    assign drain_load = (state == ST_DRAIN) && (!out_vld || out_rdy) && (drain_addr < DEPTH_C);
    assign busy       = (state != ST_LOAD);
    assign out_data   = out_vld ? out_data_q : '0;
    assign out_idx    = out_vld ? out_idx_q  : '0;

    always_comb begin
        load_flat = '0;
        for (int i = 0; i < DEPTH; i++)
            load_flat[i*DATASIZE +: DATASIZE] = load_mem[i];
    end

    rank_cmp_row #(
        .DATASIZE (DATASIZE),
        .DEPTH    (DEPTH),
        .DESCEND  (DESCEND)
    ) u_row (
        .ref_data (load_mem[rank_idx]),
        .ref_idx  (rank_idx),
        .all_data (load_flat),
        .cmp_vec  (cmp_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (in_hs && load_last) state_nxt = ST_RANK;
            ST_RANK:  if (rank_done)          state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_hs && out_last) state_nxt = ST_LOAD;
            default:                          state_nxt = ST_LOAD;
        endcase
        if (clr)
            state_nxt = ST_LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt   <= '0;
            rank_cnt   <= '0;
            drain_addr <= '0;
            vld_p1     <= 1'b0;
            out_vld    <= 1'b0;
            out_last   <= 1'b0;
            in_rdy     <= 1'b0;
        end else begin
            in_rdy <= (state_nxt == ST_LOAD);
            vld_p1 <= !clr && (state == ST_RANK) && (rank_cnt < DEPTH_C);
            if (clr) begin
                load_cnt   <= '0;
                rank_cnt   <= '0;
                drain_addr <= '0;
                out_vld    <= 1'b0;
                out_last   <= 1'b0;
            end else begin
                if (in_hs)
                    load_cnt <= load_last ? '0 : load_cnt + 1'b1;
                // Runs two past the last element so DRAIN starts only after the final buffer write.
                rank_cnt <= (state == ST_RANK) ? rank_cnt + 1'b1 : '0;
                if (state != ST_DRAIN)
                    drain_addr <= '0;
                else if (drain_load)
                    drain_addr <= drain_addr + 1'b1;
                if (drain_load) begin
                    out_vld  <= 1'b1;
                    out_last <= (drain_addr == LAST_C);
                end else if (out_hs) begin
                    out_vld  <= 1'b0;
                    out_last <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs && !clr)
            load_mem[load_cnt[IDX_W-1:0]] <= in_data;
        // Stage 1: register the compare vector for the element being ranked.
        cmp_p1  <= cmp_vec;
        idx_p1  <= rank_idx;
        data_p1 <= load_mem[rank_idx];
        // Stage 2: popcount is the sorted position; write element and its arrival index there.
        if (vld_p1) begin
            buf_data[rank_addr] <= data_p1;
            buf_idx[rank_addr]  <= idx_p1;
        end
        if (drain_load) begin
            out_data_q <= buf_data[drain_addr[IDX_W-1:0]];
            out_idx_q  <= buf_idx[drain_addr[IDX_W-1:0]];
        end
    end

endmodule

// File: tb/tb_rank_sort_stream.sv
// Bench for rank_sort_stream: ascending and descending instances share stimulus, checked against a selection-sort model.
module tb_rank_sort_stream;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr = 1'b0;
    logic       in_vld = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_rdy = 1'b0;

    logic       a_in_rdy, a_out_vld, a_out_last, a_busy;
    logic [7:0] a_out_data;
    logic [2:0] a_out_idx;
    logic       d_in_rdy, d_out_vld, d_out_last, d_busy;
    logic [7:0] d_out_data;
    logic [2:0] d_out_idx;

    int checks = 0;
    int failures = 0;

    logic [7:0] vals [N];
    logic [7:0] ea_data [N];
    logic [2:0] ea_idx [N];
    logic [7:0] ed_data [N];
    logic [2:0] ed_idx [N];

    always #5 clk = ~clk;

    rank_sort_stream #(.DATASIZE(8), .DEPTH(N), .DESCEND(0)) u_asc (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_vld(in_vld), .in_rdy(a_in_rdy), .in_data(in_data),
        .out_vld(a_out_vld), .out_rdy(out_rdy), .out_data(a_out_data),
        .out_idx(a_out_idx), .out_last(a_out_last), .busy(a_busy)
    );

    rank_sort_stream #(.DATASIZE(8), .DEPTH(N), .DESCEND(1)) u_dsc (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_vld(in_vld), .in_rdy(d_in_rdy), .in_data(in_data),
        .out_vld(d_out_vld), .out_rdy(out_rdy), .out_data(d_out_data),
        .out_idx(d_out_idx), .out_last(d_out_last), .busy(d_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stable selection sort: repeatedly take the best unused value, earliest arrival on ties.
    task automatic model();
        bit used [N];
        int best;
        for (int desc = 0; desc < 2; desc++) begin
            for (int i = 0; i < N; i++) used[i] = 1'b0;
            for (int k = 0; k < N; k++) begin
                best = -1;
                for (int j = 0; j < N; j++)
                    if (!used[j] && (best < 0 ||
                        (desc == 1 ? vals[j] > vals[best] : vals[j] < vals[best])))
                        best = j;
                used[best] = 1'b1;
                if (desc == 0) begin
                    ea_data[k] = vals[best];
                    ea_idx[k]  = 3'(best);
                end else begin
                    ed_data[k] = vals[best];
                    ed_idx[k]  = 3'(best);
                end
            end
        end
    endtask

    task automatic load_frame(input int n);
        for (int i = 0; i < n; i++) begin
            in_vld  = 1'b1;
            in_data = vals[i];
            chk("in_rdy_load_a", a_in_rdy, 1);
            chk("in_rdy_load_d", d_in_rdy, 1);
            step();
        end
        in_vld  = 1'b0;
        in_data = 8'h00;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_vld"},  a_out_vld,  0);
        chk({tag, "_out_last"}, a_out_last, 0);
        chk({tag, "_out_data"}, a_out_data, 0);
        chk({tag, "_in_rdy"},   a_in_rdy,   1);
        chk({tag, "_busy"},     a_busy,     0);
        chk({tag, "_d_out_vld"}, d_out_vld, 0);
        chk({tag, "_d_in_rdy"},  d_in_rdy,  1);
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random. abort_at >= 0 pulses clr after that many outputs.
    task automatic drain_frame(input int rdy_mode, input int abort_at);
        int lat;
        int k;
        int cyc;
        logic r;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        lat = 0;
        while (!a_out_vld && lat < 40) begin
            if (lat == 0) begin
                chk("rank_busy",     a_busy,     1);
                chk("rank_in_rdy",   a_in_rdy,   0);
                chk("rank_out_data", a_out_data, 0);
                chk("rank_out_idx",  a_out_idx,  0);
            end
            step();
            lat++;
        end
        chk("first_out_latency", lat, N + 3);
        k = 0;
        cyc = 0;
        while (k < N && cyc < 200) begin
            if (abort_at >= 0 && k == abort_at) begin
                out_rdy = 1'b0;
                clr = 1'b1;
                step();
                clr = 1'b0;
                check_idle("clr_drain");
                return;
            end
            r = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            out_rdy = r;
            chk("d_out_vld_match", d_out_vld, a_out_vld);
            if (a_out_vld) begin
                chk("asc_data", a_out_data, ea_data[k]);
                chk("asc_idx",  a_out_idx,  ea_idx[k]);
                chk("asc_last", a_out_last, (k == N - 1));
                chk("dsc_data", d_out_data, ed_data[k]);
                chk("dsc_idx",  d_out_idx,  ed_idx[k]);
                chk("dsc_last", d_out_last, (k == N - 1));
                if (r) k++;
            end
            step();
            cyc++;
        end
        out_rdy = 1'b0;
        chk("drain_count", k, N);
        check_idle("after_last");
    endtask

    task automatic rand_vals(input int maxv);
        for (int i = 0; i < N; i++) vals[i] = 8'($urandom_range(0, maxv));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_rdy",   a_in_rdy,   0);
        chk("rst_out_vld",  a_out_vld,  0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_busy",     a_busy,     0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_idx",  a_out_idx,  0);
        step();
        step();
        rst_n = 1'b1;
        chk("rel_in_rdy_low", a_in_rdy, 0);
        step();
        chk("rel_in_rdy_high", a_in_rdy, 1);

        vals[0] = 8'd7; vals[1] = 8'd3; vals[2] = 8'd9; vals[3] = 8'd1;
        vals[4] = 8'd5; vals[5] = 8'd2; vals[6] = 8'd8; vals[7] = 8'd4;
        model();
        load_frame(N);
        drain_frame(0, -1);

        for (int i = 0; i < N; i++) vals[i] = 8'h55;
        model();
        load_frame(N);
        drain_frame(0, -1);

        vals[0] = 8'd0; vals[1] = 8'd255; vals[2] = 8'd128; vals[3] = 8'd255;
        vals[4] = 8'd1; vals[5] = 8'd2;   vals[6] = 8'd3;   vals[7] = 8'd4;
        model();
        load_frame(N);
        drain_frame(1, -1);

        rand_vals(255);
        load_frame(5);
        in_vld  = 1'b1;
        in_data = 8'hEE;
        clr     = 1'b1;
        step();
        clr     = 1'b0;
        in_vld  = 1'b0;
        check_idle("clr_load");
        rand_vals(7);
        model();
        load_frame(N);
        drain_frame(0, -1);

        rand_vals(255);
        model();
        load_frame(N);
        drain_frame(2, 3);
        rand_vals(3);
        model();
        load_frame(N);
        drain_frame(2, -1);

        rand_vals(255);
        load_frame(N);
        step();
        step();
        step();
        chk("pre_rst_busy", a_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_rank_in_rdy",   a_in_rdy,   0);
        chk("rst_rank_out_vld",  a_out_vld,  0);
        chk("rst_rank_out_last", a_out_last, 0);
        chk("rst_rank_busy",     a_busy,     0);
        chk("rst_rank_out_data", a_out_data, 0);
        chk("rst_rank_out_idx",  a_out_idx,  0);
        step();
        rst_n = 1'b1;
        chk("rst_rank_rel_low", a_in_rdy, 0);
        step();
        chk("rst_rank_rel_high", a_in_rdy, 1);

        for (int f = 0; f < 4; f++) begin
            rand_vals((f % 2 == 0) ? 255 : 5);
            model();
            load_frame(N);
            drain_frame(2, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
